// File: rtl/key_encoder_if.sv
// Request/report bundle for key_encoder_8to3: active-low request lines in,
// enable and ack from the consumer; code/valid handshake plus status back.
interface key_encoder_if;
  logic [7:0] in;
  logic       en;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       lost;

  modport master (output in, en, ack, input code, valid, pending, lost);
  modport slave  (input in, en, ack, output code, valid, pending, lost);
endinterface

// File: rtl/key_encoder_8to3.sv
// Sequential 8-to-3 priority encoder for active-low request lines with a
// valid/ack handshake. Optional per-line debounce: KEY_ENCODER_DEBOUNCE_EN.
module key_encoder_8to3 #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  key_encoder_if.slave  bus
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t     state_reg, state_next;
  logic [2:0] code_reg, code_next;
  logic [7:0] sync1_reg, sync2_reg;
  logic [7:0] prev_reg;
  logic [7:0] filt;
  logic [7:0] pending_reg, pending_next;
  logic       lost_reg, lost_next;
  logic [7:0] press, capture, clear;
  logic [2:0] top_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 8'hFF;
      sync2_reg <= 8'hFF;
    end else begin
      sync1_reg <= bus.in;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef KEY_ENCODER_DEBOUNCE_EN
  logic       db_bit_reg [8];
  logic [7:0] db_cnt_reg [8];

  // A line's filtered value flips only after DB_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_bit_reg[gi] <= 1'b1;
        db_cnt_reg[gi] <= 8'd0;
      end else if (sync2_reg[gi] != db_bit_reg[gi]) begin
        if (db_cnt_reg[gi] == 8'(DB_CYCLES - 1)) begin
          db_bit_reg[gi] <= sync2_reg[gi];
          db_cnt_reg[gi] <= 8'd0;
        end else begin
          db_cnt_reg[gi] <= db_cnt_reg[gi] + 8'd1;
        end
      end else begin
        db_cnt_reg[gi] <= 8'd0;
      end
    end
    assign filt[gi] = db_bit_reg[gi];
  end
`else
  wire db_unused = ^8'(DB_CYCLES);
  assign filt = sync2_reg;
`endif

  assign press   = prev_reg & ~filt;
  assign capture = press & {8{bus.en}};
  assign clear   = (state_reg == SHOW && bus.ack) ? (8'd1 << code_reg) : 8'd0;

  // A fresh capture wins over the ack clear of the same line.
  assign pending_next = (pending_reg & ~clear) | capture;
  assign lost_next    = |(capture & pending_reg);

  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending_reg[i]) top_idx = 3'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg != 8'h00) begin
          code_next  = top_idx;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (bus.ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg    <= 8'hFF;
      pending_reg <= 8'h00;
      lost_reg    <= 1'b0;
      state_reg   <= IDLE;
      code_reg    <= 3'd0;
    end else begin
      prev_reg    <= filt;
      pending_reg <= pending_next;
      lost_reg    <= lost_next;
      state_reg   <= state_next;
      code_reg    <= code_next;
    end
  end

  assign bus.code    = code_reg;
  assign bus.valid   = (state_reg == SHOW);
  assign bus.pending = pending_reg;
  assign bus.lost    = lost_reg;

endmodule

// File: tb/tb_key_encoder_8to3.sv
// Self-checking bench for key_encoder_8to3: directed scenarios plus random
// traffic against a sample-history reference model.
module tb_key_encoder_8to3;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  key_encoder_if bus ();
  key_encoder_8to3 #(.DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference model: samples of `in` taken at each edge since reset release.
  logic [7:0] smp_q [$];
  int         m_t;
  logic [7:0] m_db, m_fprev, m_pend;
  bit         m_show, m_lost;
  logic [2:0] m_code;
  logic [7:0] r_cur, r_press, r_cap, r_clr, r_next;
  bit         r_all;

  function automatic logic [7:0] smp(int k);
    if (k < 0 || k >= smp_q.size()) return 8'hFF;
    return smp_q[k];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q.delete();
      m_t = 0; m_db = 8'hFF; m_fprev = 8'hFF; m_pend = 8'h00;
      m_show = 0; m_lost = 0; m_code = 3'd0;
    end else begin
`ifdef KEY_ENCODER_DEBOUNCE_EN
      r_cur = m_db;
`else
      r_cur = smp(m_t - 2);
`endif
      r_press = m_fprev & ~r_cur;
      r_cap   = r_press & {8{bus.en}};
      r_clr   = (m_show && bus.ack) ? (8'd1 << m_code) : 8'd0;
      r_next  = (m_pend & ~r_clr) | r_cap;
      m_lost  = (r_cap & m_pend) != 8'h00;
      if (m_show) begin
        if (bus.ack) m_show = 0;
      end else if (m_pend != 8'h00) begin
        for (int i = 7; i >= 0; i--) begin
          if (m_pend[i]) begin m_code = 3'(i); break; end
        end
        m_show = 1;
      end
`ifdef KEY_ENCODER_DEBOUNCE_EN
      // filtered bit flips when the last DB synchronized samples all disagree
      for (int b = 0; b < 8; b++) begin
        r_all = 1;
        for (int k = 0; k < DB; k++) begin
          if (smp(m_t - 2 - k)[b] == m_db[b]) r_all = 0;
        end
        if (r_all) m_db[b] = ~m_db[b];
      end
`endif
      m_pend  = r_next;
      m_fprev = r_cur;
      smp_q.push_back(bus.in);
      m_t++;
    end
  end

  task automatic tick(input logic [7:0] i, input logic e, input logic a);
    bus.in = i; bus.en = e; bus.ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.in = 8'hFF; bus.en = 1'b1; bus.ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in = 8'hFF; bus.en = 1'b1; bus.ack = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.code, bus.valid, bus.pending, bus.lost} !== 13'd0)
        $display("FAIL reset cycle %0d: code=%0d valid=%b pending=%h lost=%b, required all zero",
                 c, bus.code, bus.valid, bus.pending, bus.lost);
      else passes++;
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick(8'hFB, 1'b1, 1'b0);
      checks++;
      if (bus.valid !== (k >= 4) || (k >= 4 && bus.code !== 3'd2) || (k == 3 && bus.pending !== 8'h04))
        $display("FAIL single after %0d edges: valid=%b code=%0d pending=%h, required valid=%b code=2",
                 k, bus.valid, bus.code, bus.pending, k >= 4);
      else passes++;
    end
    tick(8'hFB, 1'b1, 1'b1);
    checks++;
    if (bus.valid !== 1'b0 || bus.pending !== 8'h00)
      $display("FAIL single_ack: valid=%b pending=%h, required valid=0 pending=00", bus.valid, bus.pending);
    else passes++;
  endtask

  task automatic test_two_lines();
    do_reset();
    repeat (4) tick(8'h7E, 1'b1, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.code !== 3'd7 || bus.pending !== 8'h81)
      $display("FAIL two_first: valid=%b code=%0d pending=%h, required 1/7/81", bus.valid, bus.code, bus.pending);
    else passes++;
    tick(8'h7E, 1'b1, 1'b1);
    checks++;
    if (bus.valid !== 1'b0 || bus.pending !== 8'h01)
      $display("FAIL two_gap: valid=%b pending=%h, required 0/01", bus.valid, bus.pending);
    else passes++;
    tick(8'h7E, 1'b1, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.code !== 3'd0)
      $display("FAIL two_second: valid=%b code=%0d, required 1/0", bus.valid, bus.code);
    else passes++;
    tick(8'h7E, 1'b1, 1'b1);
    checks++;
    if (bus.valid !== 1'b0 || bus.pending !== 8'h00)
      $display("FAIL two_done: valid=%b pending=%h, required 0/00", bus.valid, bus.pending);
    else passes++;
  endtask

  task automatic test_lost();
    int nlost = 0, nrise = 0;
    logic last_valid = 1'b0;
    logic [7:0] pat [3];
    pat[0] = 8'hF7; pat[1] = 8'hFF; pat[2] = 8'hF7;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 6; c++) begin
        tick(pat[p], 1'b1, 1'b0);
        nlost += int'(bus.lost);
        if (bus.valid && !last_valid) nrise++;
        last_valid = bus.valid;
      end
    end
    tick(8'hF7, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick(8'hF7, 1'b1, 1'b0);
      nlost += int'(bus.lost);
      if (bus.valid) nrise++;
    end
    checks++;
    if (nlost !== 1) $display("FAIL lost_pulses: got %0d, required 1", nlost);
    else passes++;
    checks++;
    if (nrise !== 1) $display("FAIL lost_reports: got %0d, required 1", nrise);
    else passes++;
  endtask

  task automatic test_enable();
    int bad = 0;
    do_reset();
    repeat (6) begin tick(8'hDF, 1'b0, 1'b0); if (bus.valid || bus.pending != 8'h00) bad++; end
    repeat (6) begin tick(8'hDF, 1'b1, 1'b0); if (bus.valid || bus.pending != 8'h00) bad++; end
    checks++;
    if (bad !== 0) $display("FAIL enable_block: %0d cycles with activity, required 0", bad);
    else passes++;
    repeat (3) tick(8'hFF, 1'b1, 1'b0);
    repeat (4) tick(8'hDF, 1'b1, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.code !== 3'd5)
      $display("FAIL enable_repress: valid=%b code=%0d, required 1/5", bus.valid, bus.code);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int got [$];
    int first_k = -1, last_k = -1, bad_gap = 0;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      tick(8'h00, 1'b1, 1'b1);
      if (bus.valid) begin
        if (last_k >= 0 && k - last_k != 2) bad_gap++;
        if (first_k < 0) first_k = k;
        last_k = k;
        got.push_back(int'(bus.code));
      end
    end
    checks++;
    if (got.size() !== 8) $display("FAIL b2b_count: got %0d codes, required 8", got.size());
    else passes++;
    for (int i = 0; i < got.size() && i < 8; i++) begin
      checks++;
      if (got[i] !== 7 - i) $display("FAIL b2b_order[%0d]: code=%0d, required %0d", i, got[i], 7 - i);
      else passes++;
    end
    checks++;
    if (bad_gap !== 0 || first_k !== 4)
      $display("FAIL b2b_spacing: bad gaps=%0d first=%0d, required 0 gaps first=4", bad_gap, first_k);
    else passes++;
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    repeat (4) tick(8'hFB, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.pending !== 8'h00)
      $display("FAIL reset_mid_show: valid=%b pending=%h, required 0/00", bus.valid, bus.pending);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick(8'hFB, 1'b1, 1'b0);
    checks++;
    if (bus.valid !== 1'b1 || bus.code !== 3'd2)
      $display("FAIL held_through_reset: valid=%b code=%0d, required 1/2", bus.valid, bus.code);
    else passes++;
  endtask

  task automatic test_random();
    logic [7:0] cur = 8'hFF;
    int errs = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
      tick(cur, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)));
      checks++;
      if (bus.valid !== m_show || bus.pending !== m_pend || bus.lost !== m_lost ||
          (m_show && bus.code !== m_code)) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle %0d: valid=%b code=%0d pending=%h lost=%b, required valid=%b code=%0d pending=%h lost=%b",
                   c, bus.valid, bus.code, bus.pending, bus.lost, m_show, m_code, m_pend, m_lost);
      end else passes++;
    end
  endtask

`ifdef KEY_ENCODER_DEBOUNCE_EN
  task automatic test_debounce();
    int bad = 0;
    do_reset();
    repeat (3) tick(8'hFD, 1'b1, 1'b0);
    repeat (10) begin tick(8'hFF, 1'b1, 1'b0); if (bus.valid || bus.pending != 8'h00) bad++; end
    checks++;
    if (bad !== 0) $display("FAIL debounce_glitch: %0d active cycles, required 0", bad);
    else passes++;
    for (int k = 1; k <= 8; k++) begin
      tick(8'hFD, 1'b1, 1'b0);
      if (k >= 7) begin
        checks++;
        if (bus.valid !== (k == 8) || (k == 8 && bus.code !== 3'd1))
          $display("FAIL debounce_hold k=%0d: valid=%b code=%0d, required valid=%b code=1",
                   k, bus.valid, bus.code, k == 8);
        else passes++;
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; bus.in = 8'hFF; bus.en = 1'b1; bus.ack = 1'b0;
    @(negedge clk);
    test_reset();
`ifdef KEY_ENCODER_DEBOUNCE_EN
    test_debounce();
`else
    test_single();
    test_two_lines();
    test_lost();
    test_enable();
    test_back_to_back();
    test_reset_mid_show();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/key_encoder_8to3.md
# key_encoder_8to3

Sequential 8-to-3 priority encoder for eight active-low request lines, the encode-side counterpart of the team's 3-to-8 active-low decoder. It synchronizes asynchronous inputs, detects press (falling) edges, queues them as pending bits and presents one 3-bit code at a time on a valid/ack handshake. It sits between external key or interrupt lines and the control logic that consumes the codes.

## Interface
- DB_CYCLES, 4, consecutive stable cycles required before an input change is accepted (used only with debounce compiled in); legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in  input  8  request lines, active-low (8'b11111111 = idle, 8'b11111011 = line 2 asserted).
- en  input  1  capture enable; low = new edges ignored.
- ack  input  1  consumer accepts the current code.
- code  output  3  index of the reported line.
- valid  output  1  code is valid.
- pending  output  8  queued, not yet reported lines (bit i = line i).
- lost  output  1  one-cycle pulse: an edge arrived on a line already pending.

## Operation
- Reset values: code=3'b000, valid=0, pending=8'h00, lost=0, both synchronizer stages and edge-history register = 8'hFF, FSM=IDLE.
- Two-flop synchronizer per line; edge-history register holds the previous synchronized value; press(i) = prev(i) & ~sync(i).
- Pending update per bit each cycle: set if press(i) & en; cleared if line i is acked this cycle; set wins when both occur.
- lost pulses the cycle after press(i) & en & pending(i) already 1; the event is coalesced (no second report).
- Priority: line 7 highest, line 0 lowest.
- FSM IDLE: when pending != 0, latch code = highest-priority pending index, assert valid, go to SHOW.
- FSM SHOW: code/valid held stable. On ack=1: clear pending(code), deassert valid, go to IDLE. ack in IDLE is ignored.
- Lines asserted while a code is shown wait in pending; higher priority does not preempt a shown code.
- en low does not affect a shown code, pending bits, or the handshake; it only blocks new captures. Edges during en=0 are lost silently.
- Release (rising) edges are not reported.
- Line held low through reset: since sync regs reset to 1, it is reported once after reset release.

## Timing
- Input falls before edge N: sync1 at N, sync2 at N+1, press true after N+1, pending set at N+2, valid=1 with code at N+3 (3-cycle latency from IDLE, no debounce).
- ack sampled high at edge M: valid=0 after M; valid low for at least one cycle; next code at M+2 earliest if pending remains.
- Back-to-back ack held high: one code per two cycles.
- Reset mid-SHOW: valid drops immediately (asynchronous); the shown code and all pending requests are discarded.

## Configuration
- KEY_ENCODER_DEBOUNCE_EN defined: per-line 8-bit counter after synchronizer; debounced value follows sync2 only after it differs for DB_CYCLES consecutive cycles (counter resets on any bounce); edge detect uses debounced value; latency 3 + DB_CYCLES. Debounced regs reset to 8'hFF, counters to 0.
- Not defined: no counters; edge detect uses sync2 directly; DB_CYCLES unused.

## Test plan
- Reset, in=8'hFF: code=0, valid=0, pending=8'h00, lost=0 for 20 cycles.
- in=8'hFB at cycle 0, ack low: valid=1, code=3'd2 at cycle 3; stays until ack; after ack valid=0, pending=8'h00.
- in 8'hFF->8'h7E same cycle (lines 0 and 7): code=7 first; ack; code=0 two cycles later; pending=8'h00 after second ack.
- Line 3 pressed, released, pressed again before ack: lost pulses once, only one code=3 reported.
- en=0 while line 5 pressed: no pending, no valid; en=1 with line 5 still held: nothing reported; release and re-press: code=5.
- With KEY_ENCODER_DEBOUNCE_EN, DB_CYCLES=4: line 1 glitch low for 3 cycles -> no report; held low 4+ cycles -> code=1, valid at cycle 7.
